// File: rtl/flash_spi_arbiter.sv
// Round-robin arbiter granting one flash transaction at a time to spi_master.
// Channels: 0 read, 1 program, 2 erase/status.
module flash_spi_arbiter #(
    parameter int GAP_CYC = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  ch_req,
    input  logic [23:0] ch_din,
    input  logic [2:0]  ch_finish,
    output logic [2:0]  ch_done,
    output logic [7:0]  ch_dout,
    output logic        m_req,
    output logic [7:0]  m_din,
    output logic        m_finish,
    input  logic        m_done,
    input  logic [7:0]  m_dout,
    output logic [1:0]  owner,
    output logic        busy
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_HOLD  = 3'd3;
    localparam logic [2:0] S_GAP   = 3'd4;

    localparam logic [15:0] GAP_LAST =
        (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);

    logic [2:0]  state;
    logic [2:0]  pend;
    logic [23:0] pdat;
    logic [2:0]  pfin;
    logic [15:0] gap_cnt;
    logic [1:0]  cand1;
    logic [1:0]  cand2;
    logic [1:0]  sel;

    function automatic logic [7:0] pick(
        input logic [23:0] d,
        input logic [1:0]  i
    );
        case (i)
            2'd0:    pick = d[7:0];
            2'd1:    pick = d[15:8];
            default: pick = d[23:16];
        endcase
    endfunction

    // Search order is owner+1, owner+2, owner (all mod 3).
    always_comb begin
        cand1 = 2'd0;
        cand2 = 2'd0;
        case (owner)
            2'd0:    begin cand1 = 2'd1; cand2 = 2'd2; end
            2'd1:    begin cand1 = 2'd2; cand2 = 2'd0; end
            default: begin cand1 = 2'd0; cand2 = 2'd1; end
        endcase
        if (pend[cand1])
            sel = cand1;
        else if (pend[cand2])
            sel = cand2;
        else
            sel = owner;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pend     <= 3'b000;
            pdat     <= 24'd0;
            pfin     <= 3'b000;
            gap_cnt  <= 16'd0;
            m_req    <= 1'b0;
            m_din    <= 8'd0;
            m_finish <= 1'b0;
            ch_done  <= 3'b000;
            ch_dout  <= 8'd0;
            owner    <= 2'd2;
            busy     <= 1'b0;
        end else begin
            m_req   <= 1'b0;
            ch_done <= 3'b000;

            for (int i = 0; i < 3; i++) begin
                if (ch_req[i] && !pend[i]) begin
                    pend[i]         <= 1'b1;
                    pdat[8*i +: 8]  <= ch_din[8*i +: 8];
                    pfin[i]         <= ch_finish[i];
                end
            end

            case (state)
                S_IDLE: begin
                    if (|pend) begin
                        owner    <= sel;
                        m_req    <= 1'b1;
                        m_din    <= pick(pdat, sel);
                        m_finish <= pfin[sel];
                        busy     <= 1'b1;
                        state    <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    pend[owner] <= 1'b0;
                    state       <= S_WAIT;
                end
                S_WAIT: begin
                    if (m_done) begin
                        ch_done <= 3'b001 << owner;
                        ch_dout <= m_dout;
                        gap_cnt <= 16'd0;
                        state   <= m_finish ? S_GAP : S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (pend[owner]) begin
                        m_req    <= 1'b1;
                        m_din    <= pick(pdat, owner);
                        m_finish <= pfin[owner];
                        state    <= S_ISSUE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt >= GAP_LAST) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 16'd1;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flash_spi_arbiter.sv
// Directed scoreboard bench for flash_spi_arbiter with a delayed-reply
// spi_master model.
module tb_flash_spi_arbiter;

    localparam int GAP = 4;

    typedef struct packed {
        logic [7:0] din;
        logic       fin;
        logic [1:0] own;
    } exp_t;

    typedef struct packed {
        logic [2:0] done;
        logic [7:0] dout;
    } dn_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  ch_req;
    logic [23:0] ch_din;
    logic [2:0]  ch_finish;
    logic [2:0]  ch_done;
    logic [7:0]  ch_dout;
    logic        m_req;
    logic [7:0]  m_din;
    logic        m_finish;
    logic        m_done;
    logic [7:0]  m_dout;
    logic [1:0]  owner;
    logic        busy;

    logic        rsp_en;
    logic        rsp_done;
    logic [7:0]  rsp_dout;
    logic        stray;
    int          rsp_cnt;
    logic [7:0]  rsp_dat;
    logic [1:0]  rsp_own;

    exp_t exp_q[$];
    dn_t  dn_q[$];

    int n_cmp = 0;
    int n_bad = 0;
    int n_mreq = 0;

    assign m_done = rsp_done | stray;
    assign m_dout = stray ? 8'hEE : rsp_dout;

    flash_spi_arbiter #(.GAP_CYC(GAP)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ch_req    (ch_req),
        .ch_din    (ch_din),
        .ch_finish (ch_finish),
        .ch_done   (ch_done),
        .ch_dout   (ch_dout),
        .m_req     (m_req),
        .m_din     (m_din),
        .m_finish  (m_finish),
        .m_done    (m_done),
        .m_dout    (m_dout),
        .owner     (owner),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard checks plus the spi_master reply model, both at negedge.
    always @(negedge clk) begin
        rsp_done = 1'b0;
        if (rst_n) begin
            if (ch_done != 3'b000) begin
                if (dn_q.size() == 0) begin
                    chk("spurious_ch_done", {29'd0, ch_done}, 32'd0);
                end else begin
                    dn_t d;
                    d = dn_q.pop_front();
                    chk("ch_done", {29'd0, ch_done}, {29'd0, d.done});
                    chk("ch_dout", {24'd0, ch_dout}, {24'd0, d.dout});
                end
            end
            if (m_req) begin
                n_mreq++;
                if (exp_q.size() == 0) begin
                    chk("spurious_m_req", {31'd0, m_req}, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("m_din", {24'd0, m_din}, {24'd0, e.din});
                    chk("m_finish", {31'd0, m_finish}, {31'd0, e.fin});
                    chk("owner", {30'd0, owner}, {30'd0, e.own});
                    if (rsp_en) begin
                        rsp_cnt = 2;
                        rsp_dat = e.din ^ 8'h5A;
                        rsp_own = e.own;
                    end
                end
            end else if (rsp_cnt > 0) begin
                rsp_cnt--;
                if (rsp_cnt == 0) begin
                    rsp_done = 1'b1;
                    rsp_dout = rsp_dat;
                    dn_q.push_back(dn_t'{done: 3'b001 << rsp_own,
                                         dout: rsp_dat});
                end
            end
        end
    end

    task automatic send(input int ch, input logic [7:0] b, input logic fin,
                        input bit push, input bit lat);
        if (push)
            exp_q.push_back(exp_t'{din: b, fin: fin, own: 2'(ch)});
        ch_req = 3'b000;
        ch_req[ch] = 1'b1;
        ch_din[8*ch +: 8] = b;
        ch_finish[ch] = fin;
        @(negedge clk);
        ch_req = 3'b000;
        @(negedge clk);
        if (lat)
            chk("latency_t2", {31'd0, m_req}, 32'd1);
    endtask

    task automatic wait_done(input int ch);
        int k;
        for (k = 0; k < 60; k++) begin
            if (ch_done[ch]) break;
            @(negedge clk);
        end
        chk($sformatf("done_wait_ch%0d", ch), {31'd0, k < 60}, 32'd1);
    endtask

    task automatic wait_idle();
        int k;
        for (k = 0; k < 100; k++) begin
            if (!busy && exp_q.size() == 0 && dn_q.size() == 0) break;
            @(negedge clk);
        end
        chk("idle_wait", {31'd0, k < 100}, 32'd1);
    endtask

    task automatic gap_measure(input string tag);
        int k;
        for (k = 0; k < 20 && !m_req; k++) @(negedge clk);
        chk(tag, k, GAP + 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        int seen;
        rst_n = 1'b0;
        ch_req = 3'b000;
        ch_din = 24'd0;
        ch_finish = 3'b000;
        stray = 1'b0;
        rsp_en = 1'b1;
        rsp_done = 1'b0;
        rsp_dout = 8'd0;
        rsp_cnt = 0;
        rsp_dat = 8'd0;
        rsp_own = 2'd0;
        repeat (3) @(negedge clk);
        chk("rst_m_req", {31'd0, m_req}, 32'd0);
        chk("rst_m_din", {24'd0, m_din}, 32'd0);
        chk("rst_m_finish", {31'd0, m_finish}, 32'd0);
        chk("rst_ch_done", {29'd0, ch_done}, 32'd0);
        chk("rst_ch_dout", {24'd0, ch_dout}, 32'd0);
        chk("rst_owner", {30'd0, owner}, 32'd2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single read on ch0
        send(0, 8'h03, 1'b0, 1, 1); wait_done(0);
        send(0, 8'hA2, 1'b0, 1, 1); wait_done(0);
        send(0, 8'hA1, 1'b0, 1, 1); wait_done(0);
        send(0, 8'hA0, 1'b0, 1, 1); wait_done(0);
        send(0, 8'h00, 1'b1, 1, 1); wait_done(0);
        wait_idle();

        // Contention between ch1 and ch2
        exp_q.push_back(exp_t'{din: 8'h06, fin: 1'b1, own: 2'd1});
        exp_q.push_back(exp_t'{din: 8'h05, fin: 1'b1, own: 2'd2});
        ch_din = {8'h05, 8'h06, 8'h00};
        ch_finish = 3'b110;
        ch_req = 3'b110;
        @(negedge clk);
        ch_req = 3'b000;
        wait_done(1);
        gap_measure("contention_gap");
        wait_done(2);
        wait_idle();

        // Lock: ch2 waits while ch0 holds the bus
        send(0, 8'h0B, 1'b0, 1, 1); wait_done(0);
        send(2, 8'h9F, 1'b1, 0, 0);
        repeat (8) @(negedge clk);
        chk("hold_no_m_req", {31'd0, m_req}, 32'd0);
        chk("hold_owner", {30'd0, owner}, 32'd0);
        chk("hold_busy", {31'd0, busy}, 32'd1);
        send(0, 8'h11, 1'b0, 1, 1); wait_done(0);
        send(0, 8'h22, 1'b1, 1, 1); wait_done(0);
        exp_q.push_back(exp_t'{din: 8'h9F, fin: 1'b1, own: 2'd2});
        gap_measure("lock_gap");
        wait_done(2);
        wait_idle();

        // Round-robin fairness
        exp_q.push_back(exp_t'{din: 8'hAA, fin: 1'b1, own: 2'd0});
        exp_q.push_back(exp_t'{din: 8'hBB, fin: 1'b1, own: 2'd1});
        exp_q.push_back(exp_t'{din: 8'hCC, fin: 1'b1, own: 2'd2});
        ch_din = {8'hCC, 8'hBB, 8'hAA};
        ch_finish = 3'b111;
        ch_req = 3'b111;
        @(negedge clk);
        ch_req = 3'b000;
        for (int c = 0; c < 3; c++) begin
            wait_done(c);
            send(c, 8'h40 + 8'(c), 1'b1, 1, 0);
        end
        for (int c = 0; c < 3; c++) wait_done(c);
        wait_idle();

        // Overrun: second pulse before ch_done is dropped
        n0 = n_mreq;
        exp_q.push_back(exp_t'{din: 8'h5C, fin: 1'b1, own: 2'd0});
        ch_din[7:0] = 8'h5C;
        ch_finish[0] = 1'b1;
        ch_req = 3'b001;
        @(negedge clk);
        ch_din[7:0] = 8'hE7;
        @(negedge clk);
        ch_req = 3'b000;
        wait_done(0);
        wait_idle();
        chk("overrun_m_req_count", n_mreq - n0, 32'd1);

        // Reset during WAIT with ch1 pending
        rsp_en = 1'b0;
        send(0, 8'h03, 1'b0, 1, 1);
        send(1, 8'h06, 1'b1, 0, 0);
        repeat (2) @(negedge clk);
        chk("pre_rst_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_m_req", {31'd0, m_req}, 32'd0);
        chk("mid_rst_m_din", {24'd0, m_din}, 32'd0);
        chk("mid_rst_m_finish", {31'd0, m_finish}, 32'd0);
        chk("mid_rst_ch_done", {29'd0, ch_done}, 32'd0);
        chk("mid_rst_ch_dout", {24'd0, ch_dout}, 32'd0);
        chk("mid_rst_owner", {30'd0, owner}, 32'd2);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        stray = 1'b1;
        @(negedge clk);
        stray = 1'b0;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (m_req || ch_done != 3'b000 || busy) seen++;
        end
        chk("post_rst_quiet", seen, 32'd0);
        rsp_en = 1'b1;
        send(0, 8'h05, 1'b1, 1, 1);
        wait_done(0);
        wait_idle();

        chk("sb_exp_empty", exp_q.size(), 32'd0);
        chk("sb_done_empty", dn_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
